// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin IF/LS arbiter onto one hold-until-ack memory port.
// Define MEM_TIMEOUT_EN to abort accesses that go TIMEOUT cycles without mem_ack.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic [DW-1:0] ls_rdata,
  output logic          ls_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          err
);
  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_LS} state_t;
  state_t state_q, state_d;
  logic last_ls_q, last_ls_d;
  logic mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d, if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic if_ready_q, if_ready_d, ls_ready_q, ls_ready_d, err_q, err_d;
  logic abort, done;
  logic [DW-1:0] rdata_sel;
`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt_q, cnt_d;
  // the last ackless cycle is the one in which the count would reach TIMEOUT
  assign abort = !mem_ack && cnt_q == TW'(TIMEOUT - 1);
  assign cnt_d = state_q == IDLE ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
`else
  assign abort = 1'b0;
`endif
  assign done      = mem_ack || abort;
  assign rdata_sel = abort ? {DW/32{32'hDEADBEEF}} : mem_rdata;
  always_comb begin
    state_d     = state_q;
    last_ls_d   = last_ls_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_ready_d  = 1'b0;
    ls_ready_d  = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE:
        if (if_req && (!ls_req || last_ls_q)) begin
          state_d     = GNT_IF;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
        end else if (ls_req) begin
          state_d     = GNT_LS;
          mem_en_d    = 1'b1;
          mem_we_d    = ls_we;
          mem_addr_d  = ls_addr;
          mem_wdata_d = ls_wdata;
        end
      GNT_IF:
        if (done) begin
          state_d    = IDLE;
          mem_en_d   = 1'b0;
          if_ready_d = 1'b1;
          if_rdata_d = rdata_sel;
          err_d      = abort;
          last_ls_d  = 1'b0;
        end
      GNT_LS:
        if (done) begin
          state_d    = IDLE;
          mem_en_d   = 1'b0;
          ls_ready_d = 1'b1;
          ls_rdata_d = rdata_sel;
          err_d      = abort;
          last_ls_d  = 1'b1;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      state_q     <= IDLE;
      last_ls_q   <= 1'b1;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      ls_ready_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_ls_q   <= last_ls_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      if_ready_q  <= if_ready_d;
      ls_ready_q  <= ls_ready_d;
      err_q       <= err_d;
    end
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign if_ready  = if_ready_q;
  assign ls_ready  = ls_ready_q;
  assign err       = err_q;
endmodule
